// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter
// Loadable modulo-MODULUS up/down counter with count enable, registered
// terminal-count pulse, saturating wrap counter and out-of-range load flag.
// Priority at each rising clock edge: reset > load > count > idle.
// The only state is data_out plus wrap_count; tc and load_err are one-cycle
// registered pulses derived from the same next-state decision.

module mod_n_updown_counter #(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 12,
    parameter int WRAP_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      data_out,
    output logic                  tc,
    output logic [WRAP_WIDTH-1:0] wrap_count,
    output logic                  load_err
);

    // Reject impossible count ranges when the block is elaborated.
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("mod_n_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    // One extra bit so that MODULUS == 2**WIDTH is representable in compares.
    localparam int EXT_W = WIDTH + 1;

    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [EXT_W-1:0] data_in_ext;
    logic             load_in_range;
    logic             at_top;
    logic             at_bottom;
    logic             wrap_full;

    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             load_err_next;

    assign data_in_ext   = {1'b0, data_in};
    assign load_in_range = (data_in_ext < MOD_EXT);
    assign at_top        = (data_out == MAX_VAL);
    assign at_bottom     = (data_out == '0);
    assign wrap_full     = &wrap_count;

    // Next count, terminal-count and load-error decision in priority order.
    always_comb begin
        count_next    = data_out;
        tc_next       = 1'b0;
        load_err_next = 1'b0;
        if (load) begin
            if (load_in_range) begin
                count_next = data_in;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (enable) begin
            if (mode) begin
                if (at_top) begin
                    count_next = '0;
                    tc_next    = 1'b1;
                end else begin
                    count_next = data_out + WIDTH'(1);
                end
            end else begin
                if (at_bottom) begin
                    count_next = MAX_VAL;
                    tc_next    = 1'b1;
                end else begin
                    count_next = data_out - WIDTH'(1);
                end
            end
        end
    end

    // Register count and pulses; wrap counter saturates instead of rolling over.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out   <= '0;
            tc         <= 1'b0;
            load_err   <= 1'b0;
            wrap_count <= '0;
        end else begin
            data_out <= count_next;
            tc       <= tc_next;
            load_err <= load_err_next;
            if (tc_next && !wrap_full) begin
                wrap_count <= wrap_count + WRAP_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench for mod_n_updown_counter: a directed vector table on the
// default configuration plus a hand-written full-range/saturation run on a
// WIDTH=3, MODULUS=8, WRAP_WIDTH=2 instance.

module tb_mod_n_updown_counter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // default instance
    logic       reset, enable, load, mode;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       tc, load_err;
    logic [7:0] wrap_count;

    // small instance
    logic       s_reset, s_enable, s_load, s_mode;
    logic [2:0] s_data_in;
    logic [2:0] s_data_out;
    logic       s_tc, s_load_err;
    logic [1:0] s_wrap_count;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(12), .WRAP_WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .mode       (mode),
        .data_in    (data_in),
        .data_out   (data_out),
        .tc         (tc),
        .wrap_count (wrap_count),
        .load_err   (load_err)
    );

    mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .WRAP_WIDTH(2)) dut_small (
        .clock      (clock),
        .reset      (s_reset),
        .enable     (s_enable),
        .load       (s_load),
        .mode       (s_mode),
        .data_in    (s_data_in),
        .data_out   (s_data_out),
        .tc         (s_tc),
        .wrap_count (s_wrap_count),
        .load_err   (s_load_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic       md;
        logic [3:0] din;
        logic [3:0] q;
        logic       tc;
        logic       err;
        logic [7:0] wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic ld, input logic en, input logic md,
                                input int din, input int q, input logic t, input logic e,
                                input int w);
        vec_t v;
        v.rst  = rst;
        v.ld   = ld;
        v.en   = en;
        v.md   = md;
        v.din  = 4'(din);
        v.q    = 4'(q);
        v.tc   = t;
        v.err  = e;
        v.wrap = 8'(w);
        return v;
    endfunction

    initial begin
        int exp_q;
        int exp_wrap;
        logic exp_tc;

        //              rst ld en md din   q  tc err wrap
        vecs.push_back(mk(1, 1, 0, 0,  5,   0, 0, 0, 0));  // reset ignores load
        vecs.push_back(mk(1, 1, 0, 0,  5,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 10,  10, 0, 0, 0));  // up-wrap
        vecs.push_back(mk(0, 0, 1, 1,  0,  11, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,  0,   0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1,  0,   1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  1,   1, 0, 0, 1));  // down-wrap
        vecs.push_back(mk(0, 0, 1, 0,  0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0,  11, 1, 0, 2));
        vecs.push_back(mk(0, 0, 1, 0,  0,  10, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0,  7,   7, 0, 0, 2));  // load range check
        vecs.push_back(mk(0, 1, 0, 0, 12,   7, 0, 1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 15,   7, 0, 1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 11,  11, 0, 0, 2));
        vecs.push_back(mk(0, 1, 1, 1,  3,   3, 0, 0, 2));  // load beats count at top
        vecs.push_back(mk(0, 0, 0, 1,  0,   3, 0, 0, 2));  // disabled holds
        vecs.push_back(mk(0, 0, 0, 1,  0,   3, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1,  0,   3, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1,  0,   3, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 11,  11, 0, 0, 2));
        vecs.push_back(mk(0, 0, 1, 1,  0,   0, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 1,  0,   0, 0, 0, 3));  // tc is a single pulse
        vecs.push_back(mk(0, 0, 1, 0,  0,  11, 1, 0, 4));  // mode flip, no penalty
        vecs.push_back(mk(0, 0, 1, 0,  0,  10, 0, 0, 4));
        vecs.push_back(mk(1, 0, 1, 1,  0,   0, 0, 0, 0));  // reset mid-count
        vecs.push_back(mk(0, 0, 1, 1,  0,   1, 0, 0, 0));  // first count from 0
        vecs.push_back(mk(0, 1, 1, 0,  0,   0, 0, 0, 0));  // load 0 beats down count
        vecs.push_back(mk(0, 1, 0, 0,  0,   0, 0, 0, 0));

        reset = 1'b1; enable = 1'b0; load = 1'b0; mode = 1'b0; data_in = '0;
        s_reset = 1'b1; s_enable = 1'b0; s_load = 1'b0; s_mode = 1'b0; s_data_in = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            load    = vecs[i].ld;
            enable  = vecs[i].en;
            mode    = vecs[i].md;
            data_in = vecs[i].din;
            @(posedge clock);
            #1;
            check("data_out", i, int'(data_out), int'(vecs[i].q));
            check("tc", i, int'(tc), int'(vecs[i].tc));
            check("load_err", i, int'(load_err), int'(vecs[i].err));
            check("wrap_count", i, int'(wrap_count), int'(vecs[i].wrap));
        end

        // Small instance: full range, load of MODULUS-1 accepted, wrap saturation.
        @(posedge clock);
        #1;
        s_reset = 1'b0;
        s_load = 1'b1; s_data_in = 3'd7;
        @(posedge clock);
        #1;
        check("s_load7_q", 0, int'(s_data_out), 7);
        check("s_load7_err", 0, int'(s_load_err), 0);
        s_data_in = 3'd0;
        @(posedge clock);
        #1;
        check("s_load0_q", 0, int'(s_data_out), 0);
        check("s_wrap_pre", 0, int'(s_wrap_count), 0);

        s_load = 1'b0; s_enable = 1'b1; s_mode = 1'b1;
        exp_q = 0;
        exp_wrap = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            exp_q  = (exp_q + 1) % 8;
            exp_tc = (exp_q == 0);
            if (exp_tc && exp_wrap < 3) exp_wrap++;
            check("s_q", c, int'(s_data_out), exp_q);
            check("s_tc", c, int'(s_tc), int'(exp_tc));
            check("s_err", c, int'(s_load_err), 0);
            check("s_wrap", c, int'(s_wrap_count), exp_wrap);
        end
        check("s_wrap_final", 0, int'(s_wrap_count), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
